adc_min_window_reader: RTL and testbench

//  Consumer of the per-channel ADC minimum stream from the min-detect pipeline.

---
 rtl/adc_min_pkg.sv | 18 +
 rtl/adc_min_lane.sv | 44 ++++
 rtl/adc_min_window_reader.sv | 135 +++++++++++++
 tb/tb_adc_min_window_reader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_min_pkg.sv
// Shared types and constants for the ADC windowed-minimum reader.
package adc_min_pkg;

   // Default per-channel sample width
   localparam int unsigned ADC_DATA_WIDTH_DEF = 8;

   // Width of the result sequence number; wraps naturally
   localparam int unsigned WIN_ID_WIDTH = 8;

   // Accumulator seed: all-ones is the identity for an unsigned minimum
   localparam logic [ADC_DATA_WIDTH_DEF-1:0] ACC_INIT = '1;

   typedef enum logic [0:0] {
      IDLE,
      ACCUM
   } state_e;

endpackage

// File: rtl/adc_min_lane.sv
// One channel of the windowed minimum: a single accumulator register folded
// with the incoming sample under control of the top-level FSM.
module adc_min_lane
   import adc_min_pkg::*;
#(
   parameter int unsigned DW = ADC_DATA_WIDTH_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          init,
   input  logic          update,
   input  logic [DW-1:0] sample,
   output logic [DW-1:0] acc
);

   // Seed replicated to the lane width so any DW gets an all-ones identity
   localparam logic [DW-1:0] InitVal = {DW{ACC_INIT[0]}};

   logic [DW-1:0] acc_q;
   logic [DW-1:0] acc_d;

   // Next accumulator: init wins over update so a completing sample in
   // continuous mode starts the next window from a clean seed
   always_comb begin
      acc_d = acc_q;
      if (init) begin
         acc_d = InitVal;
      end else if (update && (sample < acc_q)) begin
         acc_d = sample;
      end
   end

   // Accumulator register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= InitVal;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/adc_min_window_reader.sv
// Folds the per-channel ADC minimum stream into a minimum over a programmable
// number of valid samples and presents each result on a valid/ready buffer.
module adc_min_window_reader
   import adc_min_pkg::*;
#(
   parameter int unsigned ADC_DATA_WIDTH = ADC_DATA_WIDTH_DEF,
   parameter int unsigned NUM_CH         = 4,
   parameter int unsigned WIN_CNT_WIDTH  = 24
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [ADC_DATA_WIDTH*NUM_CH-1:0] min_in,
   input  logic                             min_in_valid,
   input  logic [WIN_CNT_WIDTH-1:0]         win_len,
   input  logic                             start,
   input  logic                             continuous,
   output logic                             rd_valid,
   input  logic                             rd_ready,
   output logic [ADC_DATA_WIDTH*NUM_CH-1:0] rd_data,
   output logic [WIN_ID_WIDTH-1:0]          rd_win_id,
   output logic                             busy,
   output logic                             overrun
);

   localparam int unsigned W  = ADC_DATA_WIDTH;
   localparam int unsigned DW = ADC_DATA_WIDTH * NUM_CH;

   state_e                    state_q;
   logic                      busy_q;
   logic [WIN_CNT_WIDTH-1:0]  cnt_q;
   logic [WIN_CNT_WIDTH-1:0]  len_q;
   logic                      rd_valid_q;
   logic [DW-1:0]             rd_data_q;
   logic [WIN_ID_WIDTH-1:0]   rd_win_id_q;
   logic                      overrun_q;

   logic          start_go;
   logic          take;
   logic          last;
   logic          complete;
   logic          load;
   logic          lane_init;
   logic [DW-1:0] result;

   assign start_go  = (state_q == IDLE) && start;
   assign take      = (state_q == ACCUM) && min_in_valid;
   assign last      = (cnt_q == len_q - WIN_CNT_WIDTH'(1));
   assign complete  = take && last;
   // Buffer accepts a new result when empty or drained in this same cycle
   assign load      = complete && (!rd_valid_q || rd_ready);
   assign lane_init = start_go || (complete && continuous);

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      logic [W-1:0] smp;
      logic [W-1:0] acc;

      assign smp = min_in[k*W +: W];

      adc_min_lane #(
         .DW (W)
      ) u_lane (
         .clk    (clk),
         .rst_n  (rst_n),
         .init   (lane_init),
         .update (take),
         .sample (smp),
         .acc    (acc)
      );

      // Result includes the completing sample, which the lane has not yet folded
      assign result[k*W +: W] = (smp < acc) ? smp : acc;
   end

   // Window FSM, counter, shadow length, output buffer and overrun flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         cnt_q       <= '0;
         len_q       <= WIN_CNT_WIDTH'(1);
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         rd_win_id_q <= '0;
         overrun_q   <= 1'b0;
      end else begin
         if (rd_valid_q && rd_ready) begin
            rd_valid_q <= 1'b0;
         end
         if (load) begin
            rd_valid_q  <= 1'b1;
            rd_data_q   <= result;
            rd_win_id_q <= rd_win_id_q + WIN_ID_WIDTH'(1);
         end else if (complete) begin
            overrun_q <= 1'b1;
         end

         unique case (state_q)
            IDLE: begin
               if (start) begin
                  len_q     <= (win_len == '0) ? WIN_CNT_WIDTH'(1) : win_len;
                  cnt_q     <= '0;
                  overrun_q <= 1'b0;
                  state_q   <= ACCUM;
                  busy_q    <= 1'b1;
               end
            end
            ACCUM: begin
               if (take) begin
                  if (last) begin
                     cnt_q <= '0;
                     // continuous is only consulted at the window boundary
                     if (!continuous) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     cnt_q <= cnt_q + WIN_CNT_WIDTH'(1);
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign rd_win_id = rd_win_id_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_adc_min_window_reader.sv
// Directed bench for adc_min_window_reader with a result scoreboard.
module tb_adc_min_window_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] min_in = '0;
   logic        min_in_valid = 1'b0;
   logic [23:0] win_len = '0;
   logic        start = 1'b0;
   logic        continuous = 1'b0;
   logic        rd_valid;
   logic        rd_ready = 1'b0;
   logic [31:0] rd_data;
   logic [7:0]  rd_win_id;
   logic        busy;
   logic        overrun;

   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  id;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   vec_cnt = 0;
   int   err_cnt = 0;

   adc_min_window_reader #(
      .ADC_DATA_WIDTH (8),
      .NUM_CH         (4),
      .WIN_CNT_WIDTH  (24)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .min_in       (min_in),
      .min_in_valid (min_in_valid),
      .win_len      (win_len),
      .start        (start),
      .continuous   (continuous),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .rd_data      (rd_data),
      .rd_win_id    (rd_win_id),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every accepted result must match the queue head
   always @(negedge clk) begin
      if (rst_n && rd_valid && rd_ready) begin
         if (exp_q.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL unexpected_result: got data %h id %0d, expected none", rd_data,
                     rd_win_id);
         end else begin
            mon_e = exp_q.pop_front();
            check("rd_data", rd_data, mon_e.data);
            check("rd_win_id", {24'd0, rd_win_id}, {24'd0, mon_e.id});
         end
      end
   end

   task automatic push(input logic [31:0] d, input logic [7:0] id);
      exp_t e;
      e.data = d;
      e.id   = id;
      exp_q.push_back(e);
   endtask

   task automatic step(input logic [31:0] d, input logic v);
      min_in       = d;
      min_in_valid = v;
      @(posedge clk);
      #1;
      min_in_valid = 1'b0;
   endtask

   task automatic kick();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 16; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   function automatic logic [31:0] mk1(input logic [7:0] s);
      return {8'h10 + s, 8'hFF, 8'h55, s};
   endfunction

   logic [7:0] s4[4] = '{8'd9, 8'd3, 8'd7, 8'd5};

   initial begin
      #3;
      check("reset_rd_valid", {31'd0, rd_valid}, 0);
      check("reset_rd_data", rd_data, 0);
      check("reset_rd_win_id", {24'd0, rd_win_id}, 0);
      check("reset_busy", {31'd0, busy}, 0);
      check("reset_overrun", {31'd0, overrun}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // 1: single-shot window of 4
      rd_ready = 1'b1;
      win_len  = 24'd4;
      push(32'h13FF5503, 8'd1);
      kick();
      check("t1_busy_start", {31'd0, busy}, 1);
      for (int i = 0; i < 4; i++) begin
         check("t1_no_early_valid", {31'd0, rd_valid}, 0);
         step(mk1(s4[i]), 1'b1);
      end
      check("t1_rd_valid_latency", {31'd0, rd_valid}, 1);
      check("t1_busy_done", {31'd0, busy}, 0);
      drain("t1_drain");

      // 2: same stream with zero-valued gap cycles
      push(32'h13FF5503, 8'd2);
      kick();
      for (int i = 0; i < 4; i++) begin
         step(mk1(s4[i]), 1'b1);
         if (i < 3) step(32'h0, 1'b0);
      end
      check("t2_rd_valid", {31'd0, rd_valid}, 1);
      drain("t2_drain");

      // 3: win_len 0 behaves as 1
      do_reset();
      rd_ready = 1'b1;
      win_len  = 24'd0;
      push(32'h42424242, 8'd1);
      kick();
      step(32'h42424242, 1'b1);
      check("t3_rd_valid", {31'd0, rd_valid}, 1);
      check("t3_busy", {31'd0, busy}, 0);
      drain("t3_drain");

      // 4: continuous with a stalled consumer -> overrun
      do_reset();
      rd_ready   = 1'b0;
      continuous = 1'b1;
      win_len    = 24'd2;
      kick();
      step(32'h10203040, 1'b1);
      step(32'h05060708, 1'b1);
      check("t4_first_data", rd_data, 32'h05060708);
      check("t4_first_id", {24'd0, rd_win_id}, 1);
      check("t4_busy_cont", {31'd0, busy}, 1);
      check("t4_no_overrun", {31'd0, overrun}, 0);
      step(32'h01010101, 1'b1);
      step(32'h02020202, 1'b1);
      check("t4_overrun", {31'd0, overrun}, 1);
      check("t4_data_held", rd_data, 32'h05060708);
      check("t4_id_held", {24'd0, rd_win_id}, 1);
      continuous = 1'b0;
      step(32'h03030303, 1'b1);
      step(32'h04040404, 1'b1);
      check("t4_idle", {31'd0, busy}, 0);
      check("t4_overrun_sticky", {31'd0, overrun}, 1);
      push(32'h05060708, 8'd1);
      kick();
      check("t4_overrun_cleared", {31'd0, overrun}, 0);
      rd_ready = 1'b1;
      push(32'h99999999, 8'd2);
      step(32'hAAAAAAAA, 1'b1);
      step(32'h99999999, 1'b1);
      drain("t4_drain");

      // 5: back-to-back windows of 1, accepted on every completion; id wraps
      do_reset();
      rd_ready   = 1'b1;
      continuous = 1'b1;
      win_len    = 24'd1;
      kick();
      for (int i = 0; i < 257; i++) begin
         logic [7:0]  b;
         logic [31:0] d;
         b = 8'(i);
         d = {b, ~b, 8'(i * 3), 8'(255 - i)};
         push(d, 8'(i + 1));
         if (i == 256) continuous = 1'b0;
         step(d, 1'b1);
         if (i == 255) check("t5_id_wrap", {24'd0, rd_win_id}, 0);
      end
      check("t5_no_overrun", {31'd0, overrun}, 0);
      check("t5_idle", {31'd0, busy}, 0);
      drain("t5_drain");

      // 6: asynchronous reset in the middle of a window
      do_reset();
      rd_ready   = 1'b0;
      continuous = 1'b0;
      win_len    = 24'd1;
      kick();
      step(32'h11223344, 1'b1);
      check("t6_pending", {31'd0, rd_valid}, 1);
      win_len = 24'd4;
      kick();
      step(32'h01010101, 1'b1);
      step(32'h02020202, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_rd_valid", {31'd0, rd_valid}, 0);
      check("t6_rst_rd_data", rd_data, 0);
      check("t6_rst_rd_win_id", {24'd0, rd_win_id}, 0);
      check("t6_rst_busy", {31'd0, busy}, 0);
      check("t6_rst_overrun", {31'd0, overrun}, 0);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      rd_ready = 1'b1;
      push(32'h40402001, 8'd1);
      kick();
      step(32'h80402010, 1'b1);
      step(32'h40802001, 1'b1);
      step(32'hC0C0C0C0, 1'b1);
      check("t6_no_early_valid", {31'd0, rd_valid}, 0);
      step(32'h90A0B0C0, 1'b1);
      check("t6_rd_valid", {31'd0, rd_valid}, 1);
      drain("t6_drain");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1);
   end

endmodule
